// File: rtl/alu_share_pkg.sv
// Shared definitions for the round-robin ALU sharing block: opcodes and FSM states.
package alu_share_pkg;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/alu_64bit.sv
// Purely combinational add/sub/and/xor unit with zero, sign and signed-overflow flags.
module alu_64bit
    import alu_share_pkg::*;
#(
    parameter int W = 64
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         zf,
    output logic         sf,
    output logic         of
);

    always_comb begin
        result = '0;
        of     = 1'b0;
        case (op)
            ALU_ADD: begin
                result = a + b;
                of     = (a[W-1] == b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = a - b;
                of     = (a[W-1] != b[W-1]) && (result[W-1] != a[W-1]);
            end
            ALU_AND: result = a & b;
            default: result = a ^ b;
        endcase
        zf = (result == '0);
        sf = result[W-1];
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter serialising NREQ requesters onto one shared ALU; one
// operation in flight, result and flags held until the owner accepts them.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int W    = 64,
    parameter int NREQ = 2,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ*2-1:0] req_op,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [W-1:0]      resp_result,
    output logic              resp_zf,
    output logic              resp_sf,
    output logic              resp_of,
    output logic              busy
);

    state_e         state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] gid_q, gid_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]     op_q, op_d;
    logic [W-1:0]   result_q, result_d;
    logic           zf_q, zf_d, sf_q, sf_d, of_q, of_d;

    logic [W-1:0]   alu_result;
    logic           alu_zf, alu_sf, alu_of;
    logic [IDW-1:0] win_idx, scan_idx;
    logic           win_vld;

    alu_64bit #(.W(W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .op     (op_q),
        .result (alu_result),
        .zf     (alu_zf),
        .sf     (alu_sf),
        .of     (alu_of)
    );

    // Scan from the farthest offset back to rr_ptr so the nearest valid requester wins.
    always_comb begin
        win_vld  = 1'b0;
        win_idx  = '0;
        scan_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = IDW'((int'(rr_ptr_q) + k) % NREQ);
            if (req_valid[scan_idx]) begin
                win_vld = 1'b1;
                win_idx = scan_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        gid_d    = gid_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        result_d = result_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    a_d     = req_a[int'(win_idx)*W +: W];
                    b_d     = req_b[int'(win_idx)*W +: W];
                    op_d    = req_op[int'(win_idx)*2 +: 2];
                    gid_d   = win_idx;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                result_d = alu_result;
                zf_d     = alu_zf;
                sf_d     = alu_sf;
                of_d     = alu_of;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready[gid_q]) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (gid_q == IDW'(NREQ - 1)) ? '0 : gid_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // req_ready is combinational, so it is also masked while reset is held.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        if ((state_q == ST_IDLE) && win_vld && rst_n) req_ready[win_idx] = 1'b1;
        if (state_q == ST_RESP) resp_valid[gid_q] = 1'b1;
    end

    assign busy        = (state_q != ST_IDLE);
    assign resp_result = result_q;
    assign resp_zf     = zf_q;
    assign resp_sf     = sf_q;
    assign resp_of     = of_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            gid_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            gid_q    <= gid_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            result_q <= result_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
        end
    end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 64-bit ALU (add/sub/and/xor) between NREQ requesters, using a round-robin arbiter.
- Each requester offers operands and an opcode through a valid/ready handshake. The block serialises one operation at a time, registers the result and condition flags, and returns them on a per-requester response handshake.
- Sits between the execute-stage clients and the shared ALU datapath.

Parameters:
- W, 64, operand/result width in bits.
- NREQ, 2, number of requesters (2..8).
- IDW, $clog2(NREQ) (min 1), width of the grant index.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept; one-hot or zero.
- req_a  in  NREQ*W  operand A; requester i occupies bits [i*W +: W].
- req_b  in  NREQ*W  operand B, same packing as req_a.
- req_op  in  NREQ*2  opcode, [i*2 +: 2]; 00 add, 01 sub (a-b), 10 and, 11 xor.
- resp_valid  out  NREQ  response valid; one-hot or zero.
- resp_ready  in  NREQ  per-requester response accept.
- resp_result  out  W  registered ALU result.
- resp_zf  out  1  zero flag.
- resp_sf  out  1  sign flag.
- resp_of  out  1  signed overflow flag.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset, asynchronous with rst_n=0:
  - state=IDLE; rr_ptr=0; gid=0.
  - Latched operands and opcode cleared.
  - resp_result=0; resp_zf, resp_sf, resp_of=0.
  - req_ready=0, resp_valid=0, busy=0.
- State machine IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - Winner = first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[winner]=1, combinational from req_valid and rr_ptr. All other req_ready bits = 0.
  - With no req_valid asserted, stay in IDLE with req_ready=0.
  - On the handshake: latch a, b, op and gid=winner; next state EXEC.
- EXEC (exactly 1 cycle):
  - ALU computes on the latched operands.
  - resp_result and the flags are registered at the end of the cycle; next state RESP.
- RESP:
  - resp_valid[gid]=1; all other resp_valid bits 0.
  - resp_result and the flags hold stable until the handshake.
  - When resp_ready[gid]=1: next state IDLE, rr_ptr=(gid+1) mod NREQ.
  - resp_ready bits for requesters other than gid are ignored.
- req_ready is 0 in EXEC and RESP. Minimum handshake-to-handshake turnaround is 3 cycles, and no new request is accepted in the cycle the response completes.
- Arithmetic, modulo 2^W:
  - add: a+b.
  - sub: a-b.
  - and: a&b.
  - xor: a^b.
- Flags:
  - ZF = (result==0).
  - SF = result[W-1].
  - OF for add: (a[W-1]==b[W-1]) && (result[W-1]!=a[W-1]).
  - OF for sub: (a[W-1]!=b[W-1]) && (result[W-1]!=a[W-1]).
  - OF for and/xor: 0.
- Boundary conditions:
  - All requesters valid simultaneously: strict rotation, with no requester served twice while another waits.
  - rr_ptr wraps from NREQ-1 to 0.
  - A requester may drop req_valid before it is accepted, with no side effect.
  - Reset asserted in EXEC or RESP aborts the operation, discards the pending response and returns to the reset values immediately.
  - Operands held on non-granted ports are never sampled.

Decomposition:
- Package alu_share_pkg holds:
  - opcode constants ALU_ADD=2'b00, ALU_SUB=2'b01, ALU_AND=2'b10, ALU_XOR=2'b11;
  - state encoding ST_IDLE, ST_EXEC, ST_RESP.
- Sub-module alu_64bit (parameter W, purely combinational): inputs a, b, op; outputs result, zf, sf, of.
- The arbiter, FSM and response registers stay in alu_share_arbiter.

Test Plan:
1. Single request: req0 with a=5, b=3, op=ADD, resp_ready held 1.
   - req_ready[0] high in the handshake cycle.
   - resp_valid[0] exactly 2 cycles later with result=8, zf=0, sf=0, of=0.
   - busy low again the following cycle.
2. Contention, both valid from reset with resp_ready=11:
   - req0: a=64'hFFFF_0000_FFFF_0000, b=64'h0F0F_0F0F_0F0F_0F0F, op=AND.
   - req1: a=b=64'h1234, op=XOR.
   - Required: req0 is served first (result 64'h0F0F_0000_0F0F_0000). req1 is served next (result 0, zf=1). Then req0 again, strictly alternating while both stay valid.
3. Overflow:
   - a=64'h7FFF_FFFF_FFFF_FFFF, b=1, ADD -> result=64'h8000_0000_0000_0000, sf=1, of=1.
   - a=64'h8000_0000_0000_0000, b=1, SUB -> result=64'h7FFF_FFFF_FFFF_FFFF, of=1, sf=0.
4. Response backpressure: resp_ready[1]=0 for 5 cycles after resp_valid[1] rises.
   - resp_valid[1], resp_result and the flags stay constant throughout.
   - req_ready stays 0 even with req0 valid.
   - req0 is granted 1 cycle after resp_ready[1] is asserted.
5. Reset mid-operation: assert rst_n=0 in EXEC.
   - All outputs are 0 immediately; no resp_valid after release.
   - After release, the first grant goes to requester 0 (rr_ptr=0).
6. Wrap with NREQ=3: all three requesters held valid.
   - Grant order is 0, 1, 2, 0, 1.
   - Dropping req_valid[1] before its turn gives order 0, 2, 0.
